// File: rtl/maze_map_tx.sv
// Maze-runner frame source: builds a legal 64-row obstacle map from an LFSR,
// streams it on the map bus, then polices the runner's response protocol.
module maze_map_tx #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          LAT_MAX = 3000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_out_valid,
  input  logic [1:0] i_out,
  output logic       o_in_valid,
  output logic [2:0] o_guy,
  output logic [1:0] o_in0,
  output logic [1:0] o_in1,
  output logic [1:0] o_in2,
  output logic [1:0] o_in3,
  output logic [1:0] o_in4,
  output logic [1:0] o_in5,
  output logic [1:0] o_in6,
  output logic [1:0] o_in7,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_err
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_SEND, S_WAIT} state_t;

  localparam logic [11:0] LAT_LAST = 12'(LAT_MAX - 1);

  state_t      r_state, w_state_next;
  logic [15:0] r_lfsr;
  logic [5:0]  r_idx;
  logic [2:0]  r_exit, r_reach, r_guy_hold;
  logic        r_pend;
  logic [15:0] r_mem [0:63];
  logic [15:0] r_row;
  logic [11:0] r_lat;
  logic [6:0]  r_run;
  logic        r_seen;
  logic        r_in_valid, r_busy, r_done;
  logic [2:0]  r_guy;
  logic [3:0]  r_err;

  logic        w_timeout, w_run_end;
  logic [15:0] w_lfsr_next;
  logic [1:0]  w_type, w_mark;
  logic [2:0]  w_r;
  logic [3:0]  w_exit4, w_r4, w_left4, w_right4, w_span4, w_offs4, w_new4;
  logic        w_obst;
  logic [15:0] w_obst_row, w_row;
  logic [5:0]  w_rd_addr;

  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Row type 3 folds into "free"; type 2 (jump) gets one column less reach than type 1.
  assign w_type   = (r_lfsr[1:0] == 2'd3) ? 2'd0 : r_lfsr[1:0];
  assign w_r      = (w_type == 2'd1) ? r_reach : r_reach - 3'd1;
  assign w_exit4  = {1'b0, r_exit};
  assign w_r4     = {1'b0, w_r};
  assign w_left4  = (w_exit4 >= w_r4) ? w_exit4 - w_r4 : 4'd0;
  assign w_right4 = (w_exit4 + w_r4 > 4'd7) ? 4'd7 : w_exit4 + w_r4;
  assign w_span4  = w_right4 - w_left4 + 4'd1;
  assign w_offs4  = 4'(r_lfsr[7:2] % {2'b00, w_span4});
  assign w_new4   = w_left4 + w_offs4;
  assign w_mark   = (w_type == 2'd1) ? 2'b10 : 2'b01;
  assign w_obst   = (r_idx != 6'd0) && !r_pend && (w_type != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cell
      assign w_obst_row[2*gi+1 -: 2] = (w_new4 == 4'(gi)) ? w_mark : 2'b11;
    end
  endgenerate

  assign w_row     = w_obst ? w_obst_row : 16'h0000;
  assign w_rd_addr = (r_state == S_SEND) ? r_idx + 6'd1 : 6'd0;

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_run_end    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_GEN;
      S_GEN:  if (r_idx == 6'd63) w_state_next = S_SEND;
      S_SEND: if (r_idx == 6'd63) w_state_next = S_WAIT;
      S_WAIT: begin
        if (r_seen) begin
          if (!i_out_valid) begin
            w_run_end    = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (!i_out_valid && r_lat == LAT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_GEN && !i_rst) r_mem[r_idx] <= w_row;
  end

  // Registered read doubles as the in0..in7 output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_row <= '0;
    else if (w_state_next == S_SEND) r_row <= r_mem[w_rd_addr];
    else r_row <= '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_idx      <= '0;
      r_exit     <= '0;
      r_reach    <= 3'd1;
      r_pend     <= 1'b0;
      r_guy_hold <= '0;
      r_lat      <= '0;
      r_run      <= '0;
      r_seen     <= 1'b0;
      r_in_valid <= 1'b0;
      r_guy      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_valid <= (w_state_next == S_SEND);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_timeout | w_run_end;
      r_guy      <= (r_state == S_GEN && w_state_next == S_SEND) ? r_guy_hold : 3'd0;
      r_idx      <= (r_state == S_GEN || r_state == S_SEND) ? r_idx + 6'd1 : 6'd0;

      if (r_state == S_GEN) begin
        r_lfsr <= w_lfsr_next;
        if (r_idx == 6'd0) begin
          r_guy_hold <= r_lfsr[2:0];
          r_exit     <= r_lfsr[2:0];
          r_reach    <= 3'd1;
          r_pend     <= 1'b0;
        end else if (r_pend) begin
          r_pend <= 1'b0;
        end else if (w_type == 2'd0) begin
          if (r_reach != 3'd7) r_reach <= r_reach + 3'd1;
        end else begin
          r_exit  <= w_new4[2:0];
          r_reach <= 3'd2;
          r_pend  <= 1'b1;
        end
      end

      if (r_state == S_WAIT) begin
        if (i_out_valid) begin
          r_seen <= 1'b1;
          if (r_run != 7'd127) r_run <= r_run + 7'd1;
        end else if (!r_seen) begin
          r_lat <= r_lat + 12'd1;
        end
      end else begin
        r_lat  <= '0;
        r_run  <= '0;
        r_seen <= 1'b0;
      end

      if (r_state == S_IDLE && i_start) begin
        r_err <= '0;
      end else begin
        if (w_timeout) r_err[0] <= 1'b1;
        if (w_run_end && r_run != 7'd63) r_err[1] <= 1'b1;
        if ((r_state == S_SEND || r_state == S_WAIT) && !i_out_valid && i_out != 2'd0)
          r_err[2] <= 1'b1;
        if (r_state == S_SEND && i_out_valid) r_err[3] <= 1'b1;
      end
    end
  end

  assign o_in_valid = r_in_valid;
  assign o_guy      = r_guy;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_in0      = r_row[1:0];
  assign o_in1      = r_row[3:2];
  assign o_in2      = r_row[5:4];
  assign o_in3      = r_row[7:6];
  assign o_in4      = r_row[9:8];
  assign o_in5      = r_row[11:10];
  assign o_in6      = r_row[13:12];
  assign o_in7      = r_row[15:14];

endmodule

// File: tb/tb_maze_map_tx.sv
// Bench for maze_map_tx: map contents against a row-rule model, legality of
// observed maps, and response-protocol error flags for several responders.
module tb_maze_map_tx;

  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          LAT_MAX = 3000;

  logic       clk = 1'b0;
  logic       rst, start, out_valid;
  logic [1:0] out;
  logic       in_valid, busy, done;
  logic [2:0] guy;
  logic [1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [3:0] err;

  always #5 clk = ~clk;

  maze_map_tx #(.SEED(SEED), .LAT_MAX(LAT_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_out_valid(out_valid), .i_out(out),
    .o_in_valid(in_valid), .o_guy(guy),
    .o_in0(in0), .o_in1(in1), .o_in2(in2), .o_in3(in3),
    .o_in4(in4), .o_in5(in5), .o_in6(in6), .o_in7(in7),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  wire [15:0] obs_row = {in7, in6, in5, in4, in3, in2, in1, in0};

  int          n_pass = 0, n_total = 0, n_fail = 0;
  logic [15:0] m_lfsr;
  logic [15:0] exp_rows [64];
  logic [2:0]  exp_guy;
  logic [15:0] obs_rows [64];
  logic [2:0]  obs_guy;
  logic [15:0] first_rows [64];
  logic [2:0]  first_guy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // One frame from the row rules, consuming 64 LFSR values.
  task automatic model_frame();
    int ex, rch, pend, kind, r, lo, hi, pos;
    ex = 0; rch = 1; pend = 0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] row;
      row = '0;
      if (i == 0) begin
        exp_guy = m_lfsr[2:0];
        ex = int'(m_lfsr[2:0]); rch = 1; pend = 0;
      end else if (pend != 0) begin
        pend = 0;
      end else begin
        kind = int'(m_lfsr[1:0]);
        if (kind == 3) kind = 0;
        if (kind == 0) begin
          rch = (rch < 7) ? rch + 1 : 7;
        end else begin
          r   = (kind == 1) ? rch : rch - 1;
          lo  = (ex - r < 0) ? 0 : ex - r;
          hi  = (ex + r > 7) ? 7 : ex + r;
          pos = lo + (int'(m_lfsr[7:2]) % (hi - lo + 1));
          for (int c = 0; c < 8; c++)
            row[2*c +: 2] = (c == pos) ? ((kind == 1) ? 2'b10 : 2'b01) : 2'b11;
          ex = pos; rch = 2; pend = 1;
        end
      end
      exp_rows[i] = row;
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // Structural legality of the map actually observed on the bus.
  function automatic bit legal();
    int ex, rch, pend, c1, c3, pos, r;
    logic [1:0] mk;
    if (obs_rows[0] != 16'h0) return 1'b0;
    ex = int'(obs_guy); rch = 1; pend = 0;
    for (int i = 1; i < 64; i++) begin
      logic [15:0] row;
      row = obs_rows[i];
      if (pend != 0) begin
        if (row != 16'h0) return 1'b0;
        pend = 0;
      end else if (row == 16'h0) begin
        rch = (rch < 7) ? rch + 1 : 7;
      end else begin
        c1 = 0; c3 = 0; pos = -1; mk = 2'b00;
        for (int c = 0; c < 8; c++) begin
          if (row[2*c +: 2] == 2'b11) c3++;
          else if (row[2*c +: 2] == 2'b00) return 1'b0;
          else begin c1++; pos = c; mk = row[2*c +: 2]; end
        end
        if (c1 != 1 || c3 != 7) return 1'b0;
        r = (mk == 2'b10) ? rch : rch - 1;
        if (pos - ex > r || ex - pos > r) return 1'b0;
        ex = pos; rch = 2; pend = 1;
      end
    end
    return 1'b1;
  endfunction

  // mode: 0 normal, 1 out=2 while idle, 2 out_valid in SEND, 3 start mid-SEND, 4 rst mid-SEND
  task automatic do_frame(input int mode, input int dly, input int runlen, input logic [3:0] exp_err);
    int n, k;
    model_frame();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    n = 1;
    while (!in_valid && n < 200) begin tick(); n++; end
    chk("in_valid_rise_cycle", n, 65);
    for (int j = 0; j < 64; j++) begin
      obs_rows[j] = obs_row;
      if (j == 0) obs_guy = guy;
      chk($sformatf("in_valid_row%0d", j), in_valid, 1);
      chk($sformatf("row%0d", j), obs_row, exp_rows[j]);
      chk($sformatf("guy_row%0d", j), guy, (j == 0) ? exp_guy : 3'd0);
      out_valid = (mode == 2 && j == 10);
      start     = (mode == 3 && j == 20);
      if (mode == 4 && j == 30) begin
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_in_valid", in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_guy", guy, 0);
        chk("rst_row", obs_row, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        m_lfsr = SEED;
        return;
      end
      tick();
    end
    start = 1'b0; out_valid = 1'b0;
    chk("legal_map", legal(), 1);
    chk("in_valid_fall", in_valid, 0);
    k = 0;
    while (!done && k < LAT_MAX + 100) begin
      out_valid = (runlen > 0 && k >= dly && k < dly + runlen);
      out = out_valid ? 2'($urandom_range(0, 3)) : ((mode == 1 && k == 3) ? 2'd2 : 2'd0);
      tick(); k++;
    end
    out_valid = 1'b0; out = 2'd0;
    chk("done_cycle", k, (runlen > 0) ? dly + runlen + 1 : LAT_MAX);
    chk("err_flags", err, exp_err);
    chk("busy_at_done", busy, 0);
    chk("in_valid_at_done", in_valid, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    bit same;
    rst = 1'b1; start = 1'b0; out_valid = 1'b0; out = 2'd0;
    m_lfsr = SEED;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_in_valid", in_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_err", err, 0);
      chk("idle_row", obs_row, 0);
      chk("idle_done", done, 0);
    end

    do_frame(0, 10, 63, 4'b0000);
    first_rows = obs_rows;
    first_guy  = obs_guy;
    for (int f = 1; f < 20; f++) do_frame(0, int'($urandom_range(1, 40)), 63, 4'b0000);

    do_frame(0, 0, 0, 4'b0001);
    do_frame(0, 10, 62, 4'b0010);
    do_frame(1, 10, 63, 4'b0100);
    do_frame(2, 10, 63, 4'b1000);
    do_frame(3, 10, 63, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_queued_start", busy, 0);
    end

    do_frame(4, 10, 63, 4'b0000);
    tick();
    chk("rst_beats_start", busy, 0);
    do_frame(0, 10, 63, 4'b0000);
    same = (obs_guy == first_guy);
    for (int i = 0; i < 64; i++) if (obs_rows[i] != first_rows[i]) same = 1'b0;
    chk("repro_after_rst", same, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maze_map_tx.md
# maze_map_tx

Hardware frame source for the maze-runner interface. It generates a legal 64-row obstacle map from an internal LFSR and buffers it. It then drives the map and start position on `in_valid/guy/in0..in7` for exactly 64 contiguous cycles. Afterwards it monitors the runner's `out_valid/out` response for protocol violations. It sits opposite the runner core on the same bus, replacing a behavioural stimulus generator in on-chip self-test.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `LAT_MAX`, 3000: maximum cycles allowed from `in_valid` falling to `out_valid` rising.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request for a new frame. Accepted only in IDLE.
- `out_valid` in 1: runner output valid.
- `out` in 2: runner move.
- `in_valid` out 1: map valid, high for exactly 64 contiguous cycles per frame.
- `guy` out 3: start column, valid only on the first `in_valid` cycle; 0 otherwise.
- `in0`..`in7` out 2 each: the current row's cell for columns 0..7. All are 0 when `in_valid` is low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of the response check.
- `err` out 4: sticky error flags, cleared on an accepted `start`.
  - [0] latency exceeded.
  - [1] `out_valid` run length ≠ 63.
  - [2] `out` ≠ 0 while `out_valid` = 0.
  - [3] `out_valid` = 1 while `in_valid` = 1.

## Operation
- States: IDLE → GEN (64 cycles) → SEND (64 cycles) → WAIT (until response ends or times out) → IDLE.
- Cell codes:
  - 00: free.
  - 01: low obstacle, must be jumped.
  - 10: high obstacle, walk under.
  - 11: wall.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It loads `SEED` on reset and steps once per GEN cycle only.
- The buffer is 64 rows × 16 bits. Column k of a row sits in bits [2k+1:2k]. The buffer is not reset and is fully overwritten each frame.
- GEN writes one row per cycle, i = 0..63.
- GEN state registers:
  - `exit` (3 bits): the last exit column.
  - `reach` (3 bits, 1..7): how far the next exit may move from `exit`.
  - `pend` (1 bit): a zero row is owed after an obstacle row.
- Row 0: all 00. `guy` and `exit` load `lfsr[2:0]`; `reach` = 1.
- Row i ≥ 1 with `pend` = 1: write all 00 and clear `pend`.
- Row i ≥ 1 with `pend` = 0: type = `lfsr[1:0]`, with value 3 treated as 0.
  - Type 0: write all 00. `reach` = min(`reach`+1, 7).
  - Type 1: r = `reach`. Write all 11, with the exit column set to 10.
  - Type 2: r = `reach`−1. Write all 11, with the exit column set to 01.
- Exit column selection for types 1/2:
  - left = max(`exit`−r, 0); right = min(`exit`+r, 7).
  - new exit = left + (`lfsr[7:2]` mod (right−left+1)).
  - Update `exit`, set `reach` = 2, set `pend` = 1.
- An obstacle may land on row 63. No trailing zero row is written, and `pend` is discarded.
- SEND: row j drives `in0..in7` on cycle j (j = 0..63). `guy` is driven on j = 0 only.
- WAIT: `lat` (12-bit) counts cycles after `in_valid` falls.
  - If `lat` reaches `LAT_MAX` with `out_valid` never seen high: set `err[0]`, pulse `done`, go to IDLE.
  - Once `out_valid` is seen, `run` (7-bit) counts high cycles.
  - On the first low cycle after the run: set `err[1]` if `run` ≠ 63, pulse `done`, go to IDLE.
- `err[2]` and `err[3]` are sampled every cycle in SEND and WAIT.
- `start` while `busy` is ignored, with no queueing.

## Timing
- Reset values:
  - State IDLE, LFSR = `SEED`.
  - All outputs 0: `in_valid`, `guy`, `in*`, `busy`, `done`, `err`.
- `start` sampled high in IDLE: `busy` = 1 the next cycle.
- GEN occupies cycles 1..64 after `start`. `in_valid` rises on cycle 65 and stays high through cycle 128.
- All outputs are registered. `in*` change only on the edge that begins each SEND cycle.
- `done` is asserted for one cycle together with the transition to IDLE. `busy` falls in the same cycle as `done`.
- The earliest new `start` is accepted the cycle after `done`.
- `rst` asserted in any state, including mid-SEND: the next cycle shows IDLE and all outputs 0. The frame is abandoned.
- Simultaneous `start` and `rst`: `rst` wins.

## Test plan
- Reset: hold `rst` 2 cycles, then check `in_valid`=0, `busy`=0, `err`=0, `in0..in7`=0 for 5 idle cycles.
- Frame legality, default `SEED`, 20 frames:
  - `in_valid` high exactly 64 cycles, `guy` ∈ 0..7 on the first cycle only.
  - Row 0 all 00.
  - Every 11-row has exactly one 01/10 cell.
  - The row after an obstacle row (if < 64) is all 00.
  - Exit distance ≤ the reach rule.
- Compliant responder: `out_valid` high 63 cycles starting 10 cycles after `in_valid` falls, `out`=0 when low → `done` pulse, `err`=0000.
- Silent responder: no `out_valid` → `done` exactly 3000 cycles after `in_valid` falls, `err`=0001.
- Faulty responders:
  - 62-cycle run → `err[1]`.
  - `out`=2 while `out_valid`=0 → `err[2]`.
  - `out_valid`=1 during SEND → `err[3]`.
- `start` pulsed mid-SEND is ignored, and the frame completes unchanged. `rst` at SEND cycle 30 gives all outputs 0 next cycle. A new `start` then reproduces the first post-reset frame bit-exactly.
